// File: rtl/comb_pascal_engine_if.sv
// Request/response bundle between the top-level controller and the
// bottom-up combination engine: start/n/m in, busy/done/result out.
interface comb_pascal_engine_if #(
   parameter int N_W   = 4,
   parameter int RES_W = 13
);
   logic             start;
   logic [N_W-1:0]   n;
   logic [N_W-1:0]   m;
   logic             busy;
   logic             done;
   logic [RES_W-1:0] result;

   // Controller side: issues requests and consumes results.
   modport master (
      output start, n, m,
      input  busy, done, result
   );

   // Engine side: accepts requests and produces results.
   modport slave (
      input  start, n, m,
      output busy, done, result
   );
endinterface

// File: rtl/comb_pascal_engine.sv
// Bottom-up combination engine: builds Pascal's triangle in place in a row
// buffer, one element per cycle, walking j downwards so each cycle is a single
// read-modify-write with no row copy, then returns C(n, m).
module comb_pascal_engine #(
   parameter int N_W   = 4,
   parameter int RES_W = 13
) (
   input  logic                 clk,
   input  logic                 rst,
   comb_pascal_engine_if.slave  bus
);

   localparam int DEPTH = 1 << N_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INIT   = 2'd1,
      COL    = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [N_W-1:0]   i;
   logic [N_W-1:0]   j;
   logic [N_W-1:0]   n_q;
   logic [N_W-1:0]   m_q;
   logic             busy_q;
   logic             done_q;
   logic [RES_W-1:0] result_q;
   logic [RES_W-1:0] row [DEPTH];

   logic             j_is_one;
   logic             row_last;

   // Entries are counts; wrap-around is the defined behaviour if RES_W is
   // ever made too narrow for the largest C(n, m).
   function automatic logic [RES_W-1:0] add_wrap(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
      return a + b;
   endfunction

   assign j_is_one = (j == N_W'(1));
   assign row_last = j_is_one && (i == n_q);

   // Next-state decode for the INIT -> COL* -> FINISH walk.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = INIT;
         INIT:    state_next = (n_q == '0) ? FINISH : COL;
         COL:     if (row_last) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset aborts any request in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Control, operand latch, row/column indices and the result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i        <= '0;
         j        <= '0;
         n_q      <= '0;
         m_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  n_q    <= bus.n;
                  m_q    <= bus.m;
                  busy_q <= 1'b1;
               end
            end
            INIT: begin
               i <= N_W'(1);
               j <= N_W'(1);
            end
            COL: begin
               if (j_is_one) begin
                  // Row i complete; next row starts at its rightmost new slot.
                  if (i < n_q) begin
                     i <= i + N_W'(1);
                     j <= i + N_W'(1);
                  end
               end else begin
                  j <= j - N_W'(1);
               end
            end
            FINISH: begin
               result_q <= (m_q > n_q) ? '0 : row[m_q];
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Row buffer: cleared to row 0 in INIT, updated in place during COL.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         for (int k = 0; k < DEPTH; k++)
            row[k] <= (k == 0) ? RES_W'(1) : '0;
      end else if (state == COL) begin
         row[j] <= add_wrap(row[j], row[j - N_W'(1)]);
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_comb_pascal_engine.sv
// Scoreboard bench for comb_pascal_engine: each accepted request pushes its
// expected result and latency; the monitor pops on every done pulse.
module tb_comb_pascal_engine;

   localparam int N_W   = 4;
   localparam int RES_W = 13;

   logic clk;
   logic rst;
   int   cyc;
   int   errors;
   int   checks;
   int   exp_hold;

   typedef struct {
      int res;
      int lat;
      int start_cyc;
      int n;
      int m;
   } sb_entry_t;

   sb_entry_t sb[$];

   comb_pascal_engine_if #(.N_W(N_W), .RES_W(RES_W)) bus ();

   comb_pascal_engine #(.N_W(N_W), .RES_W(RES_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Independent model: multiplicative binomial, 0 for m > n.
   function automatic int binom(input int nn, input int mm);
      longint c;
      if (mm > nn) return 0;
      c = 1;
      for (int k = 0; k < mm; k++) c = c * (nn - k) / (k + 1);
      return int'(c % (1 << RES_W));
   endfunction

   function automatic int latency(input int nn);
      return 3 + nn * (nn + 1) / 2;
   endfunction

   // Present one start pulse; caller is positioned just after a clock edge.
   task automatic issue(input int nn, input int mm, input bit push);
      sb_entry_t e;
      bus.start = 1'b1;
      bus.n     = N_W'(nn);
      bus.m     = N_W'(mm);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.n     = N_W'($urandom_range(0, 15));
      bus.m     = N_W'($urandom_range(0, 15));
      if (push) begin
         e.res       = binom(nn, mm);
         e.lat       = latency(nn);
         e.start_cyc = cyc;
         e.n         = nn;
         e.m         = mm;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!bus.done && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!bus.done) check_eq("done_timeout", 0, 1);
   endtask

   // Monitor: reset values, result hold, busy while pending, and done pops.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         check_eq("rst_busy", int'(bus.busy), 0);
         check_eq("rst_done", int'(bus.done), 0);
         check_eq("rst_result", int'(bus.result), 0);
      end else if (bus.done) begin
         if (sb.size() == 0) begin
            check_eq("spurious_done", 1, 0);
         end else begin
            sb_entry_t e;
            e = sb.pop_front();
            check_eq($sformatf("result_n%0d_m%0d", e.n, e.m), int'(bus.result), e.res);
            check_eq($sformatf("latency_n%0d", e.n), cyc - e.start_cyc + 1, e.lat);
            check_eq("busy_in_done", int'(bus.busy), 0);
            exp_hold = e.res;
         end
      end else begin
         check_eq("result_hold", int'(bus.result), exp_hold);
         if (sb.size() != 0) check_eq("busy_pending", int'(bus.busy), 1);
      end
   end

   initial begin
      int s;
      cyc       = 0;
      errors    = 0;
      checks    = 0;
      exp_hold  = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.n     = '0;
      bus.m     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic request
      issue(5, 2, 1'b1);
      wait_done(200);

      // Largest row, then a zero-gap request started in the done cycle
      issue(15, 7, 1'b1);
      wait_done(200);
      issue(15, 0, 1'b1);
      wait_done(200);

      // n = 0 and m > n
      issue(0, 0, 1'b1);
      wait_done(200);
      issue(4, 6, 1'b1);
      wait_done(200);

      // start while busy is ignored
      issue(6, 3, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.n     = N_W'(2);
      bus.m     = N_W'(1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(200);
      repeat (10) @(posedge clk);
      #1;

      // Reset mid-computation aborts without a done
      issue(10, 4, 1'b1);
      s = sb[sb.size() - 1].start_cyc;
      while (cyc < s + 19) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_eq("abort_busy", int'(bus.busy), 0);
      check_eq("abort_done", int'(bus.done), 0);
      check_eq("abort_result", int'(bus.result), 0);
      sb.delete();
      exp_hold = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      issue(10, 4, 1'b1);
      wait_done(200);

      // Full sweep, back to back
      for (int nn = 0; nn < 16; nn++) begin
         for (int mm = 0; mm < 16; mm++) begin
            issue(nn, mm, 1'b1);
            wait_done(200);
         end
      end

      repeat (5) @(posedge clk);
      #1;
      check_eq("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
